ipsxe_floating_point_invsqrt_horner_v1_0: RTL
=============================================

IPSXE_FLOATING_POINT_INVSQRT_HORNER_V1_0 -- requirements
Module: ipsxe_floating_point_invsqrt_horner_v1_0

Interface
REQ-001 The block SHALL have parameter COEF_W, default 52, coefficient and result width (unsigned fixed point, common scale).
REQ-002 The block SHALL have parameter DX_W, default 44, width of dx; all DX_W bits are fraction bits (value = i_dx / 2^DX_W).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 i_clk  input  1  clock; all state updates on rising edge.
REQ-005 i_rst  input  1  asynchronous active-high reset.
REQ-006 i_valid  input  1  operand valid.
REQ-007 o_ready  output  1  block can accept an operand.
REQ-008 i_x_hi8  input  8  segment index; selects the coefficient set.
REQ-009 i_dx  input  DX_W  offset (x - a) of the segment, unsigned.
REQ-010 o_x_hi8  output  8  registered segment index driven to the a0..a6 LUTs.
REQ-011 o_coef_idx  output  3  coefficient order requested (0..6).
REQ-012 i_coef  input  COEF_W  coefficient a[o_coef_idx] for o_x_hi8, combinational return from LUT mux, same cycle.
REQ-013 o_valid  output  1  result valid.
REQ-014 i_ready  input  1  downstream accepts result.
REQ-015 o_result  output  COEF_W  series value a0 - a1*d + a2*d^2 - ... + a6*d^6.
REQ-016 o_underflow  output  1  at least one Horner step saturated to 0 for this result.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, ITER, DONE; o_ready = 1 only in IDLE.
REQ-018 IDLE: on i_valid && o_ready, the block SHALL capture i_x_hi8 into o_x_hi8 and i_dx, clear the underflow flag, go LOAD.
REQ-019 LOAD: o_coef_idx = 6; accumulator r <= i_coef; 3-bit counter k <= 5; go ITER.
REQ-020 ITER: o_coef_idx = k; r <= i_coef - P, P = (r * dx) >> DX_W (full COEF_W+DX_W product); k decrements; after k = 0 step go DONE.
REQ-021 If i_coef < P in any step, r SHALL be 0 and the underflow flag SHALL set (sticky until next acceptance).
REQ-022 Latency: o_valid SHALL rise 7 cycles after the acceptance edge (LOAD 1 + ITER 6).
REQ-023 DONE: o_valid = 1, o_result = r, o_underflow = flag, held stable until i_ready; on o_valid && i_ready go IDLE.
REQ-024 o_result and o_underflow SHALL change only on LOAD/ITER updates; i_valid outside IDLE SHALL be ignored.
REQ-025 o_coef_idx in IDLE and DONE SHALL be 0.
REQ-026 Minimum initiation interval SHALL be 9 cycles (IDLE, LOAD, 6 ITER, DONE with i_ready = 1).

Reset
REQ-027 i_rst SHALL immediately force state IDLE, o_valid = 0, o_ready = 1 after release, o_result = 0, o_underflow = 0, o_x_hi8 = 0, o_coef_idx = 0, k = 0, captured dx = 0.
REQ-028 Reset mid-operation SHALL abandon the computation with no result emitted.

Configuration
REQ-029 Macro IPSXE_FLOATING_POINT_INVSQRT_ROUND_EN defined: P = (r*dx + 2^(DX_W-1)) >> DX_W (round half up); undefined: P truncates (floor). Latency and interface are identical in both builds.

Verification (stub LUT returns listed coefficients)
REQ-030 All coefficients = 2^40, i_dx = 2^43 (0.5) -> o_result = 43*2^34 = 0xAC_0000_0000, o_underflow = 0, o_valid 7 cycles after acceptance; same in both builds.
REQ-031 a6 = 3, a5..a0 = 10, i_dx = 2^43 -> o_result = 7 without macro, 6 with IPSXE_FLOATING_POINT_INVSQRT_ROUND_EN.
REQ-032 i_dx = 0, a0 = 0x59fb5ed31a53a -> o_result = 0x59fb5ed31a53a; o_coef_idx sequence 6,5,4,3,2,1,0 observed.
REQ-033 a6 = 2^COEF_W - 1, a5..a0 = 0, i_dx = 2^DX_W - 1 -> o_result = 0, o_underflow = 1; next op with i_dx = 0 -> o_underflow = 0.
REQ-034 i_ready = 0 for 5 cycles in DONE -> o_valid/o_result stable, o_ready = 0, i_valid ignored; i_ready = 1 -> IDLE next cycle.
REQ-035 i_rst pulsed during ITER (k = 3) -> o_valid never asserts for that operand; next operand yields correct result.

Source files
------------

// File: rtl/ipsxe_floating_point_invsqrt_horner_v1_0.sv
// Horner evaluation of a0 - a1*d + ... + a6*d^6, one coefficient per cycle from an external LUT.
// Define IPSXE_FLOATING_POINT_INVSQRT_ROUND_EN for round-half-up step products (default: truncate).
module ipsxe_floating_point_invsqrt_horner_v1_0 #(
   parameter int unsigned COEF_W = 52,
   parameter int unsigned DX_W   = 44
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [7:0]        i_x_hi8,
   input  logic [DX_W-1:0]   i_dx,
   output logic [7:0]        o_x_hi8,
   output logic [2:0]        o_coef_idx,
   input  logic [COEF_W-1:0] i_coef,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [COEF_W-1:0] o_result,
   output logic              o_underflow
);

   localparam int unsigned PROD_W = COEF_W + DX_W;

`ifdef IPSXE_FLOATING_POINT_INVSQRT_ROUND_EN
   localparam logic [PROD_W:0] RND = {{(PROD_W + 1 - DX_W){1'b0}}, 1'b1, {(DX_W - 1){1'b0}}};
`else
   localparam logic [PROD_W:0] RND = '0;
`endif

   typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

   state_t              state, state_nxt;
   logic [DX_W-1:0]     dx_q;
   logic [COEF_W-1:0]   r_q;
   logic [2:0]          k_q;
   logic                uf_q;

   logic [PROD_W:0]     prod;
   logic [COEF_W:0]     p_full;
   logic                step_uf;
   logic [COEF_W-1:0]   step_r;

   // One extra product bit keeps the rounding increment from wrapping
   assign prod    = (PROD_W + 1)'(r_q) * (PROD_W + 1)'(dx_q) + RND;
   assign p_full  = (COEF_W + 1)'(prod >> DX_W);
   assign step_uf = {1'b0, i_coef} < p_full;
   assign step_r  = step_uf ? '0 : i_coef - p_full[COEF_W-1:0];

   always_comb begin
      state_nxt  = state;
      o_ready    = 1'b0;
      o_valid    = 1'b0;
      o_coef_idx = '0;
      case (state)
         IDLE: begin
            o_ready = 1'b1;
            if (i_valid) state_nxt = LOAD;
         end
         LOAD: begin
            o_coef_idx = 3'd6;
            state_nxt  = ITER;
         end
         ITER: begin
            o_coef_idx = k_q;
            if (k_q == 3'd0) state_nxt = DONE;
         end
         DONE: begin
            o_valid = 1'b1;
            if (i_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state   <= IDLE;
         o_x_hi8 <= '0;
         dx_q    <= '0;
         r_q     <= '0;
         k_q     <= '0;
         uf_q    <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (i_valid) begin
                  o_x_hi8 <= i_x_hi8;
                  dx_q    <= i_dx;
                  uf_q    <= 1'b0;
               end
            end
            LOAD: begin
               r_q <= i_coef;
               k_q <= 3'd5;
            end
            ITER: begin
               r_q  <= step_r;
               uf_q <= uf_q | step_uf;
               if (k_q != 3'd0) k_q <= k_q - 3'd1;
            end
            default: ;
         endcase
      end
   end

   assign o_result    = r_q;
   assign o_underflow = uf_q;

endmodule
